multiple_comparator_feeder: RTL and testbench

MULTIPLE_COMPARATOR_FEEDER -- requirements
Module: multiple_comparator_feeder

---
 rtl/multiple_comparator_feeder.sv | 146 ++++++++++++++
 tb/tb_multiple_comparator_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiple_comparator_feeder.sv
// Serial-to-parallel feeder for a 4-input, 2-stage comparator tree: collects four samples,
// pulses io_start for two cycles, latches the tree result and offers it downstream.
// Optional build macro FEEDER_RESULT_COUNT_EN adds a 16-bit completed-result counter io_count.
module multiple_comparator_feeder (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [6:0]  io_in_bits,
    output logic [6:0]  io_inputs_0,
    output logic [6:0]  io_inputs_1,
    output logic [6:0]  io_inputs_2,
    output logic [6:0]  io_inputs_3,
    output logic        io_start,
    input  logic [6:0]  io_result,
    output logic        io_out_valid,
    input  logic        io_out_ready,
`ifdef FEEDER_RESULT_COUNT_EN
    output logic [15:0] io_count,
`endif
    output logic [6:0]  io_out_bits
);

    localparam logic [2:0] S_COLLECT = 3'd0;
    localparam logic [2:0] S_RUN0    = 3'd1;
    localparam logic [2:0] S_RUN1    = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_cnt;
    logic [6:0] r_in0;
    logic [6:0] r_in1;
    logic [6:0] r_in2;
    logic [6:0] r_in3;
    logic [6:0] r_out_bits;
    logic       w_accept;
    logic       w_out_fire;

    assign w_accept   = io_in_valid && (r_state == S_COLLECT);
    assign w_out_fire = io_out_ready && (r_state == S_OUT);

    // Next-state selection for the collect / run / latch / output sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_accept && (r_cnt == 2'd3)) begin
                    w_next_state = S_RUN0;
                end else begin
                    w_next_state = S_COLLECT;
                end
            end
            S_RUN0:  w_next_state = S_RUN1;
            S_RUN1:  w_next_state = S_LATCH;
            S_LATCH: w_next_state = S_OUT;
            S_OUT: begin
                if (w_out_fire) begin
                    w_next_state = S_COLLECT;
                end else begin
                    w_next_state = S_OUT;
                end
            end
            default: w_next_state = S_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sample slot counter; wraps to 0 on the fourth accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 2'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Operand registers: written only while collecting, so they stay frozen through the run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in0 <= 7'd0;
            r_in1 <= 7'd0;
            r_in2 <= 7'd0;
            r_in3 <= 7'd0;
        end else if (w_accept) begin
            case (r_cnt)
                2'd0:    r_in0 <= io_in_bits;
                2'd1:    r_in1 <= io_in_bits;
                2'd2:    r_in2 <= io_in_bits;
                2'd3:    r_in3 <= io_in_bits;
                default: r_in0 <= r_in0;
            endcase
        end else begin
            r_in0 <= r_in0;
        end
    end

    // Result register: the tree output is valid during LATCH after its two advance cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_bits <= 7'd0;
        end else if (r_state == S_LATCH) begin
            r_out_bits <= io_result;
        end else begin
            r_out_bits <= r_out_bits;
        end
    end

`ifdef FEEDER_RESULT_COUNT_EN
    logic [15:0] r_count;

    // Completed-result counter, wraps naturally at 16 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_out_fire) begin
            r_count <= r_count + 16'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign io_count = r_count;
`endif

    assign io_in_ready  = (r_state == S_COLLECT);
    assign io_start     = (r_state == S_RUN0) || (r_state == S_RUN1);
    assign io_out_valid = (r_state == S_OUT);
    assign io_out_bits  = r_out_bits;
    assign io_inputs_0  = r_in0;
    assign io_inputs_1  = r_in1;
    assign io_inputs_2  = r_in2;
    assign io_inputs_3  = r_in3;

endmodule

// File: tb/tb_multiple_comparator_feeder.sv
// Self-checking bench for multiple_comparator_feeder, driving it with a behavioural
// 2-stage min comparator tree; table-driven transactions plus reset corner sequences.
module tb_multiple_comparator_feeder;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [6:0]  io_in_bits;
    logic [6:0]  io_inputs_0;
    logic [6:0]  io_inputs_1;
    logic [6:0]  io_inputs_2;
    logic [6:0]  io_inputs_3;
    logic        io_start;
    logic [6:0]  io_result;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [6:0]  io_out_bits;
`ifdef FEEDER_RESULT_COUNT_EN
    logic [15:0] io_count;
`endif

    int n_pass;
    int n_total;
    int exp_count;

    multiple_comparator_feeder dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_inputs_0  (io_inputs_0),
        .io_inputs_1  (io_inputs_1),
        .io_inputs_2  (io_inputs_2),
        .io_inputs_3  (io_inputs_3),
        .io_start     (io_start),
        .io_result    (io_result),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
`ifdef FEEDER_RESULT_COUNT_EN
        .io_count     (io_count),
`endif
        .io_out_bits  (io_out_bits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural min comparator tree, advancing one stage per io_start cycle.
    logic [6:0] st1a, st1b, st2;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st1a <= 7'd0;
            st1b <= 7'd0;
            st2  <= 7'd0;
        end else if (io_start) begin
            st1a <= (io_inputs_0 < io_inputs_1) ? io_inputs_0 : io_inputs_1;
            st1b <= (io_inputs_2 < io_inputs_3) ? io_inputs_2 : io_inputs_3;
            st2  <= (st1a < st1b) ? st1a : st1b;
        end
    end
    assign io_result = st2;

    typedef struct {
        logic [3:0][6:0] s;
        int              gap;
        int              hold;
        logic [6:0]      exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [6:0] inp(input int k);
        case (k)
            0: return io_inputs_0;
            1: return io_inputs_1;
            2: return io_inputs_2;
            default: return io_inputs_3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction: feed 4 samples, follow the run, hold OUT, then handshake.
    task automatic run_txn(input logic [3:0][6:0] s, input int gap, input int hold,
                           input logic [6:0] exp_res, input string tag);
        int lat;
        int starts;
        int bad_ready;
        int bad_hold;
        io_out_ready = (hold == 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                io_in_valid = 1'b0;
                tick();
            end
            chk({tag, "_in_ready"}, {31'd0, io_in_ready}, 32'd1);
            io_in_valid = 1'b1;
            io_in_bits  = s[k];
            tick();
            io_in_valid = 1'b0;
            chk($sformatf("%s_order%0d", tag, k), {25'd0, inp(k)}, {25'd0, s[k]});
        end
        // Junk samples offered while busy must be ignored.
        io_in_valid = 1'b1;
        io_in_bits  = 7'h55;
        // Latency counted from the accepting cycle: RUN0=1, RUN1=2, LATCH=3, OUT=4.
        lat       = 1;
        starts    = 0;
        bad_ready = 0;
        while (!io_out_valid && lat < 20) begin
            if (io_start) starts++;
            if (io_in_ready) bad_ready++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_start_cycles"}, starts, 32'd2);
        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            if (!io_out_valid || io_out_bits !== exp_res || io_start || io_in_ready) bad_hold++;
            tick();
        end
        chk({tag, "_hold"}, bad_hold, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (inp(k) !== s[k]) bad_ready++;
        end
        chk({tag, "_busy_stable"}, bad_ready, 32'd0);
        io_out_ready = 1'b1;
        io_in_valid  = 1'b0;
        chk({tag, "_out_valid"}, {31'd0, io_out_valid}, 32'd1);
        chk({tag, "_result"}, {25'd0, io_out_bits}, {25'd0, exp_res});
        chk({tag, "_ready_in_hs"}, {31'd0, io_in_ready}, 32'd0);
        tick();
        exp_count++;
        io_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, io_out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, io_in_ready}, 32'd1);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        exp_count    = 0;
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_bits   = 7'd0;
        io_out_ready = 1'b0;

        vecs[0] = '{s: '{7'd7, 7'd9, 7'd3, 7'd5}, gap: 0, hold: 0, exp_res: 7'd3};
        vecs[1] = '{s: '{7'd100, 7'd100, 7'd100, 7'd100}, gap: 0, hold: 0, exp_res: 7'd100};
        vecs[2] = '{s: '{7'd7, 7'd9, 7'd3, 7'd5}, gap: 0, hold: 10, exp_res: 7'd3};
        vecs[3] = '{s: '{7'd90, 7'd7, 7'd40, 7'd12}, gap: 0, hold: 0, exp_res: 7'd7};
        vecs[4] = '{s: '{7'd90, 7'd7, 7'd40, 7'd12}, gap: 2, hold: 0, exp_res: 7'd7};
        vecs[5] = '{s: '{7'd1, 7'd64, 7'd0, 7'd127}, gap: 1, hold: 3, exp_res: 7'd0};
        vecs[6] = '{s: '{7'd127, 7'd127, 7'd127, 7'd127}, gap: 0, hold: 0, exp_res: 7'd127};

        #12;
        chk("rst_start", {31'd0, io_start}, 32'd0);
        chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("rst_out_bits", {25'd0, io_out_bits}, 32'd0);
        chk("rst_inputs_0", {25'd0, io_inputs_0}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, io_in_ready}, 32'd1);
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].s, vecs[i].gap, vecs[i].hold, vecs[i].exp_res, $sformatf("v%0d", i));
`ifdef FEEDER_RESULT_COUNT_EN
            if (i == 2) chk("count_after3", {16'd0, io_count}, 32'd3);
`endif
        end
`ifdef FEEDER_RESULT_COUNT_EN
        chk("count_all", {16'd0, io_count}, exp_count);
`endif

        // Reset after two accepted samples discards the partial collection.
        io_in_valid = 1'b1;
        io_in_bits  = 7'd8;
        tick();
        io_in_bits  = 7'd2;
        tick();
        io_in_valid = 1'b0;
        reset = 1'b1;
        #1;
        exp_count = 0;
        chk("midrst_inputs_0", {25'd0, io_inputs_0}, 32'd0);
        chk("midrst_inputs_1", {25'd0, io_inputs_1}, 32'd0);
        chk("midrst_out_bits", {25'd0, io_out_bits}, 32'd0);
        chk("midrst_start", {31'd0, io_start}, 32'd0);
`ifdef FEEDER_RESULT_COUNT_EN
        chk("count_rst", {16'd0, io_count}, 32'd0);
`endif
        #2;
        reset = 1'b0;
        tick();
        run_txn({7'd9, 7'd4, 7'd1, 7'd6}, 0, 0, 7'd1, "midrst");

        // Reset while a result is pending in OUT drops it.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            io_in_bits = 7'd20 + 7'(k);
            tick();
        end
        io_in_valid = 1'b0;
        for (int w = 0; w < 20 && !io_out_valid; w++) tick();
        chk("outrst_pending", {31'd0, io_out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("outrst_valid", {31'd0, io_out_valid}, 32'd0);
        chk("outrst_bits", {25'd0, io_out_bits}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("outrst_in_ready", {31'd0, io_in_ready}, 32'd1);
        tick();
        run_txn({7'd33, 7'd44, 7'd55, 7'd66}, 0, 0, 7'd33, "post_rst");
`ifdef FEEDER_RESULT_COUNT_EN
        chk("count_post_rst", {16'd0, io_count}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
